div_seq: RTL and testbench

Iterative 32-bit integer divider for the datapath's DIV/DIVU path. It computes quotient and remainder by restoring shift-subtract, one quotient bit per clock, so it reuses a single WIDTH-bit subtract stage instead of an array. It sits beside the combinational ALU and adder and is launched by the control unit through a start/busy/done handshake; results feed the HI/LO registers.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 42 ++++
 rtl/div_seq.sv | 150 +++++++++++++++
 tb/tb_div_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    // Default operand/result width of the divider.
    localparam int DIV_WIDTH = 32;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Iteration counter width able to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring shift-subtract step.
//  Revision    : 1.0  initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Partial remainder after shifting in the next dividend bit. It can need
    // WIDTH+1 bits because the previous remainder is below the divisor.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_dvs_inv;
    logic [WIDTH+1:0] w_sum;
    logic             w_carry;
    logic             w_unused;

    assign w_shift   = {rem_in, bit_in};
    assign w_dvs_inv = ~{1'b0, dvs};

    // Subtract as add-with-inverted-operand plus carry-in; carry out of the
    // WIDTH+1-bit sum means the trial difference is non-negative.
    assign w_sum   = {1'b0, w_shift} + {1'b0, w_dvs_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_carry = w_sum[WIDTH+1];

    // A successful trial is below the divisor and a failed one leaves the
    // shifted value below the divisor, so the top bit is always zero here.
    assign rem_out  = w_carry ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign q_bit    = w_carry;
    assign w_unused = w_sum[WIDTH] ^ w_shift[WIDTH];

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Iterative signed/unsigned integer divider, one quotient bit
//                per clock, start/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_nq;
    logic             r_nr;
    logic             r_dz;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_qbit;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_dvs_zero = (divisor == '0);
    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~divisor  + WIDTH'(1)) : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_quo[WIDTH-1]),
        .dvs     (r_dvs),
        .rem_out (w_rem_nxt),
        .q_bit   (w_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: zero divisor skips the iterations entirely.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_dvs_zero ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: operand capture and one restore step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_nq  <= 1'b0;
            r_nr  <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvs <= w_dvs_mag;
            r_nq  <= w_dvd_neg ^ w_dvs_neg;
            r_nr  <= w_dvd_neg;
            r_dz  <= w_dvs_zero;
            // Divide-by-zero reports the dividend untouched, so keep it raw.
            r_quo <= w_dvs_zero ? dividend : w_dvd_mag;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        end
    end

    // Result registers: sign fix-up and done pulse, updated only at FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (r_state == FIX) begin
            done        <= 1'b1;
            div_by_zero <= r_dz;
            if (r_dz) begin
                quotient  <= '1;
                remainder <= r_quo;
            end else begin
                quotient  <= r_nq ? ('0 - r_quo) : r_quo;
                remainder <= r_nr ? ('0 - r_rem) : r_rem;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Scoreboard testbench for div_seq with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               done_cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    div_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to measure latency.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one start cycle; caller positions this just after a falling edge.
    task automatic issue(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit push, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edz, input int lat, input string name);
        exp_t e;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.q        = eq;
            e.r        = er;
            e.dz       = edz;
            e.done_cyc = cyc + lat;
            e.name     = name;
            sb.push_back(e);
        end
        // Operands are free to change once captured.
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compare every completion against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_q"},   quotient,  e.q);
                chk({e.name, "_r"},   remainder, e.r);
                chk({e.name, "_dz"},  {{(WIDTH-1){1'b0}}, div_by_zero}, {{(WIDTH-1){1'b0}}, e.dz});
                chk({e.name, "_lat"}, WIDTH'(cyc), WIDTH'(e.done_cyc));
                chk({e.name, "_busy"}, {{(WIDTH-1){1'b0}}, busy}, '0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, '0);
        chk("rst_done", {31'd0, done}, '0);
        chk("rst_q",    quotient,  '0);
        chk("rst_r",    remainder, '0);
        chk("rst_dz",   {31'd0, div_by_zero}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned basic divide, with busy check right after capture.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, LAT, "u100_7");
        chk("run_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Signed: truncation toward zero, remainder follows dividend sign.
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT, "sn7_2");
        wait_idle();
        @(negedge clk);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT, "s7_n2");
        wait_idle();

        // Divide by zero: unsigned and signed (remainder is the raw dividend).
        @(negedge clk);
        issue(1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, "u5_0");
        wait_idle();
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, "sn5_0");
        wait_idle();

        // Signed overflow wraps; also clears the zero flag.
        @(negedge clk);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 1'b0, LAT, "s_ovf");
        wait_idle();

        // Unsigned extremes.
        @(negedge clk);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, "umax_1");
        wait_idle();
        @(negedge clk);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 1'b0, LAT, "u_small");
        wait_idle();

        // start pulsed mid-RUN is ignored.
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd10, 1, 32'd100, 32'd0, 1'b0, LAT, "u1000_10");
        repeat (10) @(negedge clk);
        is_signed = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // start in the done cycle is accepted.
        @(negedge clk);
        issue(1'b0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 1'b0, LAT, "u50_5");
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 100);
        end
        issue(1'b0, 32'd23, 32'd4, 1, 32'd5, 32'd3, 1'b0, LAT, "u23_4");
        wait_idle();

        // Asynchronous reset mid-operation abandons the divide.
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd7, 0, '0, '0, 1'b0, 0, "abandon");
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, '0);
        chk("arst_q",    quotient,  '0);
        chk("arst_r",    remainder, '0);
        chk("arst_dz",   {31'd0, div_by_zero}, '0);
        #4;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        @(negedge clk);
        issue(1'b0, 32'd9, 32'd3, 1, 32'd3, 32'd0, 1'b0, LAT, "u9_3");
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
